pwm_duty_ctrl: RTL and testbench

// - Upstream stage of the PWM pulse generator: turns raw board switches into a clean, slew-limited duty command.
// - Per-bit 2-flop synchronise and debounce; sw[0] is run-enable, sw[3:1] is the 3-bit duty code.
// - Output duty_wide uses the PWM compare format {1'b0, code[2:0], {CBITS-4{1'b0}}}.
// - Changes are applied only on PWM period boundaries (period_tick), so there are no mid-period glitches.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/sw_debounce.sv | 46 ++++
 rtl/pwm_duty_ctrl.sv | 155 +++++++++++++++
 tb/tb_pwm_duty_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty-command front end.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package pwm_pkg;

   localparam int CODE_W = 3;

   typedef enum logic [1:0] {IDLE, UP, DOWN} duty_state_t;

   // Place the 3-bit code just below the MSB of the PWM compare word: {1'b0, code, zeros}.
   function automatic logic [63:0] duty_to_wide(input logic [CODE_W-1:0] code, input int cbits);
      return 64'(code) << (cbits - 4);
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One raw switch bit -> 2-flop synchroniser -> stable-time debouncer.
// Latency: 2 sync cycles plus DB_CYCLES stable cycles before deb follows.
// Backpressure: none; free-running, always accepts input.
module sw_debounce #(
   parameter int DB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic deb
);

   localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser for the asynchronous switch input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept the synchronised value only after DB_CYCLES consecutive differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         deb <= 1'b0;
      end else if (sync2 == deb) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         deb <= sync2;
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Switches -> debounced run/code -> duty command, changed only on PWM period boundaries.
// Latency: 2 sync + DB_CYCLES debounce, then outputs update the cycle after a qualifying period_tick.
// Backpressure: none. Build option PWM_DUTY_RAMP_EN: slew-limit to one code step per RAMP_PERIODS ticks.
module pwm_duty_ctrl
   import pwm_pkg::*;
#(
   parameter int CBITS        = 20,
   parameter int DB_CYCLES    = 50000,
   parameter int RAMP_PERIODS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       sw,
   input  logic             period_tick,
   output logic [CBITS-1:0] duty_wide,
   output logic [2:0]       duty_code,
   output logic             busy
);

   if (CBITS < 5) begin : g_bad_cbits
      $error("pwm_duty_ctrl: CBITS must be >= 5");
   end
   if (DB_CYCLES < 2) begin : g_bad_db
      $error("pwm_duty_ctrl: DB_CYCLES must be >= 2");
   end
   if (RAMP_PERIODS < 1) begin : g_bad_ramp
      $error("pwm_duty_ctrl: RAMP_PERIODS must be >= 1");
   end

   logic [3:0]        deb;
   logic [CODE_W-1:0] target;
   logic [CODE_W-1:0] code_n;

   for (genvar i = 0; i < 4; i++) begin : g_db
      sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (sw[i]),
         .deb   (deb[i])
      );
   end

   // Run-enable gates the requested code; with run off the command falls to zero.
   assign target = deb[0] ? deb[3:1] : '0;

`ifdef PWM_DUTY_RAMP_EN

   localparam int              RCW       = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
   localparam logic [RCW-1:0]  RAMP_LAST = RCW'(RAMP_PERIODS - 1);

   duty_state_t    state_q;
   duty_state_t    state_n;
   logic [RCW-1:0] ramp_q;
   logic [RCW-1:0] ramp_n;
   logic           step_due;

   assign step_due = period_tick && (ramp_q == RAMP_LAST);

   // Ramp FSM: direction decided every cycle, code moves one step only on a due tick.
   always_comb begin
      state_n = state_q;
      code_n  = duty_code;
      ramp_n  = ramp_q;
      case (state_q)
         IDLE: begin
            ramp_n = '0;
            if (target > duty_code)      state_n = UP;
            else if (target < duty_code) state_n = DOWN;
         end
         UP: begin
            if (target == duty_code) begin
               state_n = IDLE;
               ramp_n  = '0;
            end else if (target < duty_code) begin
               state_n = DOWN;   // reversal keeps the partial tick count
            end else if (period_tick) begin
               if (step_due) begin
                  code_n = duty_code + CODE_W'(1);
                  ramp_n = '0;
                  if (code_n == target) state_n = IDLE;
               end else begin
                  ramp_n = ramp_q + RCW'(1);
               end
            end
         end
         DOWN: begin
            if (target == duty_code) begin
               state_n = IDLE;
               ramp_n  = '0;
            end else if (target > duty_code) begin
               state_n = UP;
            end else if (period_tick) begin
               if (step_due) begin
                  code_n = duty_code - CODE_W'(1);
                  ramp_n = '0;
                  if (code_n == target) state_n = IDLE;
               end else begin
                  ramp_n = ramp_q + RCW'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            ramp_n  = '0;
         end
      endcase
   end

   // State, tick counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ramp_q    <= '0;
         duty_code <= '0;
         duty_wide <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_n;
         ramp_q    <= ramp_n;
         duty_code <= code_n;
         duty_wide <= CBITS'(duty_to_wide(code_n, CBITS));
         busy      <= (state_n != IDLE);
      end
   end

   // The code can never step past its range: UP only steps below target, DOWN only above it.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == UP && target > duty_code && step_due) |-> (duty_code != '1));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == DOWN && target < duty_code && step_due) |-> (duty_code != '0));

`else

   // Without slew limiting the code jumps straight to target on the next tick.
   always_comb begin
      code_n = duty_code;
      if (period_tick && (target != duty_code)) code_n = target;
   end

   // Registered outputs; busy flags a pending change still waiting for a tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_code <= '0;
         duty_wide <= '0;
         busy      <= 1'b0;
      end else begin
         duty_code <= code_n;
         duty_wide <= CBITS'(duty_to_wide(code_n, CBITS));
         busy      <= (code_n != target);
      end
   end

`endif

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl with DB_CYCLES=4, RAMP_PERIODS=2, CBITS=20, tick every 8 clk.
// Expected codes are hand-derived; step timing is measured against the bench's own tick counter.
// Expectations follow the PWM_DUTY_RAMP_EN setting the design is built with.
module tb_pwm_duty_ctrl;

   localparam int CBITS = 20;
   localparam int DB    = 4;
   localparam int RP    = 2;

   logic             clk         = 1'b0;
   logic             rst_n       = 1'b1;
   logic [3:0]       sw          = 4'hF;
   logic             period_tick = 1'b0;
   logic [CBITS-1:0] duty_wide;
   logic [2:0]       duty_code;
   logic             busy;

   int     n_total     = 0;
   int     n_pass      = 0;
   int     tick_cnt    = 0;
   int     prev_tick   = 0;
   longint last_tick_t = 0;
   logic   bad;

   pwm_duty_ctrl #(
      .CBITS        (CBITS),
      .DB_CYCLES    (DB),
      .RAMP_PERIODS (RP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw          (sw),
      .period_tick (period_tick),
      .duty_wide   (duty_wide),
      .duty_code   (duty_code),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Free-running period tick: one cycle high every 8 clocks; records when it was sampled.
   initial begin
      forever begin
         repeat (7) @(posedge clk);
         #1 period_tick = 1'b1;
         @(posedge clk);
         tick_cnt++;
         last_tick_t = $time;
         #1 period_tick = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_change(input string tag, input logic [2:0] old);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #2;
         if (duty_code !== old) return;
      end
      n_total++;
      $error("FAIL %s_timeout: duty_code stuck at %0d, expected a change", tag, duty_code);
   endtask

   task automatic step(input string tag, input logic [2:0] old, input logic [2:0] exp,
                       input bit gap, input logic exp_busy);
      wait_change(tag, old);
      chk({tag, "_code"}, 32'(duty_code), 32'(exp));
      chk({tag, "_wide"}, 32'(duty_wide), 32'(exp) << 16);
      chk({tag, "_busy"}, 32'(busy), 32'(exp_busy));
      chk({tag, "_on_tick"}, 32'($time - last_tick_t), 32'd2);
      if (gap) chk({tag, "_gap"}, 32'(tick_cnt - prev_tick), 32'(RP));
      prev_tick = tick_cnt;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #2;
         if (busy === 1'b0 && duty_code === 3'd0) break;
      end
      chk({tag, "_code"}, 32'(duty_code), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic mid_reset(input string tag);
      #1 rst_n = 1'b0;
      #1;
      chk({tag, "_async_code"}, 32'(duty_code), 32'd0);
      chk({tag, "_async_wide"}, 32'(duty_wide), 32'd0);
      chk({tag, "_async_busy"}, 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk({tag, "_post_code"}, 32'(duty_code), 32'd0);
   endtask

   initial begin
      // Reset with all switches on: outputs clear asynchronously, before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_code", 32'(duty_code), 32'd0);
      chk("rst_wide", 32'(duty_wide), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

`ifdef PWM_DUTY_RAMP_EN
      // Ramp from 0 towards 7, one step per 2 ticks; reset at code 4.
      step("ramp_a1", 3'd0, 3'd1, 1'b0, 1'b1);
      step("ramp_a2", 3'd1, 3'd2, 1'b1, 1'b1);
      step("ramp_a3", 3'd2, 3'd3, 1'b1, 1'b1);
      step("ramp_a4", 3'd3, 3'd4, 1'b1, 1'b1);
      mid_reset("midrst");
      step("restart1", 3'd0, 3'd1, 1'b0, 1'b1);
      sw = 4'b0000;
      wait_idle("off_a");
`else
      // Immediate jump to 7 on the first tick after debounce; reset, then jump again.
      step("jump7", 3'd0, 3'd7, 1'b0, 1'b0);
      mid_reset("midrst");
      step("rejump7", 3'd0, 3'd7, 1'b0, 1'b0);
      sw = 4'b0000;
      step("drop0", 3'd7, 3'd0, 1'b0, 1'b0);
`endif

      // Bouncing run-enable: high for only 2 cycles at a time, never accepted.
      sw  = 4'b1010;
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sw[0] = ~sw[0];
         repeat (2) begin
            @(posedge clk);
            #2;
            if (duty_code !== 3'd0 || busy !== 1'b0) bad = 1'b1;
         end
      end
      sw[0] = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #2;
         if (duty_code !== 3'd0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("bounce_quiet", 32'(bad), 32'd0);
      chk("bounce_code", 32'(duty_code), 32'd0);

`ifdef PWM_DUTY_RAMP_EN
      // Ramp up to code 5 and settle.
      sw = 4'b1011;
      step("up1", 3'd0, 3'd1, 1'b0, 1'b1);
      step("up2", 3'd1, 3'd2, 1'b1, 1'b1);
      step("up3", 3'd2, 3'd3, 1'b1, 1'b1);
      step("up4", 3'd3, 3'd4, 1'b1, 1'b1);
      step("up5", 3'd4, 3'd5, 1'b1, 1'b0);
      sw = 4'b0000;
      wait_idle("off_b");

      // Run switched off at code 3: reverse and ramp down at the same spacing.
      sw = 4'b1011;
      step("re1", 3'd0, 3'd1, 1'b0, 1'b1);
      step("re2", 3'd1, 3'd2, 1'b1, 1'b1);
      step("re3", 3'd2, 3'd3, 1'b1, 1'b1);
      sw = 4'b1010;
      step("dn2", 3'd3, 3'd2, 1'b1, 1'b1);
      step("dn1", 3'd2, 3'd1, 1'b1, 1'b1);
      step("dn0", 3'd1, 3'd0, 1'b1, 1'b0);
`else
      // Direct jumps between several codes, including run-off with code bits still set.
      sw = 4'b1011;
      step("jump5", 3'd0, 3'd5, 1'b0, 1'b0);
      sw = 4'b1010;
      step("runoff0", 3'd5, 3'd0, 1'b0, 1'b0);
      sw = 4'b1101;
      step("jump6", 3'd0, 3'd6, 1'b0, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
